wrr_egress_scheduler: RTL
=========================

Name: wrr_egress_scheduler

Overview:
Per-egress-port weighted round-robin packet scheduler for the packet switch crossbar. It selects one ingress port whose tdest matches this egress and holds that selection for a whole packet, from the first beat to the tlast beat. It drives the crossbar mux select, the egress valid/last and the per-ingress ready. Per-ingress weights (packets per round) are programmed from the switch's Avalon-MM register block. One instance exists per egress port.

Parameters:
N_PORTS, 4, number of ingress ports.
IDX_WIDTH, 2, width of a port index; must equal clog2(N_PORTS).
WEIGHT_WIDTH, 4, width of a per-ingress weight and credit counter.

Ports:
clk  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
cfg_write  in  1  weight write strobe, single-cycle.
cfg_addr  in  IDX_WIDTH  ingress index whose weight is written.
cfg_wdata  in  WEIGHT_WIDTH  new weight; 0 disables that ingress for this egress.
ingress_valid  in  N_PORTS  tvalid of each ingress.
ingress_last  in  N_PORTS  tlast of each ingress.
ingress_dst  in  N_PORTS*IDX_WIDTH  tdest of each ingress, packed with ingress j at bits [j*IDX_WIDTH +: IDX_WIDTH].
egress_port_id  in  IDX_WIDTH  this instance's egress index; static.
egress_ready  in  1  egress tready.
selected_ingress  out  IDX_WIDTH  crossbar mux select.
egress_valid  out  1  egress tvalid.
egress_last  out  1  egress tlast.
grant  out  N_PORTS  one-hot grant to the locked ingress.
ingress_ready  out  N_PORTS  this egress's contribution to each ingress tready.
busy  out  1  high while a packet is locked.

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - weight[j]=1 and credit[j]=1 for all j (plain round-robin).
  - rr pointer = 0.
- Request vector: req[j] = ingress_valid[j] & (dst[j]==egress_port_id) & (weight[j]!=0).
- Eligible vector: elig[j] = req[j] & (credit[j]!=0).
- IDLE:
  - If elig is nonzero: pick the first set bit of elig, searching cyclically from the pointer.
  - If elig is zero but req is nonzero: reload credit[j]=weight[j] for all j, and pick from req in the same cycle.
  - On a pick: register sel and go to LOCKED. This costs one bubble cycle per packet; no data moves in IDLE.
- LOCKED:
  - selected_ingress=sel; grant=onehot(sel); busy=1.
  - egress_valid = ingress_valid[sel]; egress_last = ingress_last[sel] & ingress_valid[sel].
  - ingress_ready[sel] = egress_ready; all other ingress_ready bits are 0.
  - Beat transfer = egress_valid & egress_ready. A transfer with last ends the packet.
  - A valid bubble from the ingress mid-packet keeps the lock; there is no timeout.
- End of packet:
  - credit[sel] decrements, saturating at 0.
  - If the decremented credit is nonzero, the pointer stays at sel (that ingress keeps priority). Otherwise the pointer moves to sel+1, wrapping mod N_PORTS.
  - Next state is IDLE.
  - Back-to-back packets therefore have 1 bubble cycle; a single-beat packet takes 2 cycles per grant.
- Outputs in IDLE: selected_ingress holds its last value; valid, last, grant, ingress_ready and busy are 0.
- Config writes:
  - A write takes effect the next cycle in any state. The current packet is never affected.
  - Credit clamp: if credit[a] > the new weight, credit[a] = new weight.
  - A write in the same cycle as a reload: the reload uses cfg_wdata for the written index.
- Destination changes: a change of dst[sel] mid-packet is ignored; the lock holds until tlast.
- Reset mid-packet: immediate return to IDLE with all outputs 0. The partial packet is truncated; this is the upstream owner's concern.

Optional Feature:
PKT_COUNT_EN.
- Defined: adds output pkt_count, 16 bits, reset 0. It increments on each end-of-packet transfer and wraps from 0xFFFF to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Shared package packet_filter_pkg holds:
  - scheduler state enum {IDLE, LOCKED};
  - constants DEFAULT_WEIGHT=1 and PKT_COUNT_WIDTH=16.
- One combinational sub-module, rr_first_set (params N_PORTS, IDX_WIDTH). Inputs: request vector and start pointer. Outputs: found flag and index of the first set bit at or after the pointer, wrapping.

Test Plan:
- Defaults; ingress 0 and 2 each send 2-beat packets to egress 1 continuously, egress_ready=1 → grant order 0,2,0,2; each packet takes 3 cycles (1 bubble).
- Weight[0]=3, weight[2]=1; both ingress saturate → packet order 0,0,0,2,0,0,0,2.
- Write weight[2]=0 while ingress 2 is requesting → ingress 2 is never granted; ingress 0 gets all grants; ingress_ready[2]=0 throughout.
- Locked 4-beat packet with egress_ready toggling 1,0,1,0… → exactly 4 transfers, egress_last only on beat 4, no grant change mid-packet; ingress dst changes mid-packet are ignored.
- Reset asserted on beat 2 of a 4-beat packet → next edge: busy=0, grant=0, egress_valid=0, pointer=0, weights back to 1.
- With PKT_COUNT_EN: 70000 single-beat packets → pkt_count = 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/packet_filter_pkg.sv
// Shared types and constants for the packet switch egress schedulers.
package packet_filter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } sched_state_t;

   localparam int DEFAULT_WEIGHT  = 1;
   localparam int PKT_COUNT_WIDTH = 16;

endpackage

// File: rtl/rr_first_set.sv
// Cyclic priority search: index of the first set request bit at or after ptr,
// wrapping past the top port back to port 0.
module rr_first_set #(
   parameter int N_PORTS   = 4,
   parameter int IDX_WIDTH = 2
) (
   input  logic [N_PORTS-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] idx
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found = |req;
      idx   = ptr;
      cand  = 0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= N_PORTS) cand = cand - N_PORTS;
         if (req[cand]) idx = IDX_WIDTH'(cand);
      end
   end

endmodule

// File: rtl/wrr_egress_scheduler.sv
// Per-egress weighted round-robin packet scheduler: locks one ingress per packet.
// Optional PKT_COUNT_EN adds a 16-bit wrapping end-of-packet counter output.
module wrr_egress_scheduler
   import packet_filter_pkg::*;
#(
   parameter int N_PORTS      = 4,
   parameter int IDX_WIDTH    = 2,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cfg_write,
   input  logic [IDX_WIDTH-1:0]          cfg_addr,
   input  logic [WEIGHT_WIDTH-1:0]       cfg_wdata,
   input  logic [N_PORTS-1:0]            ingress_valid,
   input  logic [N_PORTS-1:0]            ingress_last,
   input  logic [N_PORTS*IDX_WIDTH-1:0]  ingress_dst,
   input  logic [IDX_WIDTH-1:0]          egress_port_id,
   input  logic                          egress_ready,
   output logic [IDX_WIDTH-1:0]          selected_ingress,
   output logic                          egress_valid,
   output logic                          egress_last,
   output logic [N_PORTS-1:0]            grant,
   output logic [N_PORTS-1:0]            ingress_ready,
   output logic                          busy
`ifdef PKT_COUNT_EN
   ,
   output logic [PKT_COUNT_WIDTH-1:0]    pkt_count
`endif
);

   sched_state_t             state_q, state_d;
   logic [IDX_WIDTH-1:0]     sel_q, sel_d, ptr_q, ptr_d;
   logic [WEIGHT_WIDTH-1:0]  weight_q [N_PORTS];
   logic [WEIGHT_WIDTH-1:0]  credit_q [N_PORTS];
   logic [WEIGHT_WIDTH-1:0]  credit_d [N_PORTS];
   logic [WEIGHT_WIDTH-1:0]  credit_dec;
   logic [N_PORTS-1:0]       req, elig, pick_vec;
   logic                     pick_found, reload, eop, beat_xfer;
   logic [IDX_WIDTH-1:0]     pick_idx;

   always_comb begin
      req  = '0;
      elig = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         req[j]  = ingress_valid[j]
                   && (ingress_dst[j*IDX_WIDTH +: IDX_WIDTH] == egress_port_id)
                   && (weight_q[j] != '0);
         elig[j] = req[j] && (credit_q[j] != '0);
      end
   end

   // With every requester out of credit, the round restarts from req directly.
   assign pick_vec = (elig != '0) ? elig : req;

   rr_first_set #(
      .N_PORTS   (N_PORTS),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_rr_first_set (
      .req   (pick_vec),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign selected_ingress = sel_q;

   // Valid/ready: a beat moves on a cycle where egress_valid and egress_ready are
   // both high; egress_ready is routed only to the locked ingress.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      ptr_d         = ptr_q;
      reload        = 1'b0;
      eop           = 1'b0;
      beat_xfer     = 1'b0;
      egress_valid  = 1'b0;
      egress_last   = 1'b0;
      grant         = '0;
      ingress_ready = '0;
      busy          = 1'b0;
      credit_dec    = (credit_q[sel_q] == '0) ? '0 : credit_q[sel_q] - WEIGHT_WIDTH'(1);
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               reload  = (elig == '0);
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            busy                 = 1'b1;
            grant[sel_q]         = 1'b1;
            egress_valid         = ingress_valid[sel_q];
            egress_last          = ingress_last[sel_q] & ingress_valid[sel_q];
            ingress_ready[sel_q] = egress_ready;
            beat_xfer            = egress_valid & egress_ready;
            if (beat_xfer && egress_last) begin
               eop     = 1'b1;
               state_d = IDLE;
               if (credit_dec != '0) ptr_d = sel_q;
               else ptr_d = (sel_q == IDX_WIDTH'(N_PORTS - 1)) ? '0 : sel_q + IDX_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A weight write wins over a same-cycle reload and clamps any larger credit.
   always_comb begin
      for (int j = 0; j < N_PORTS; j++) begin
         credit_d[j] = credit_q[j];
         if (reload)
            credit_d[j] = (cfg_write && cfg_addr == IDX_WIDTH'(j)) ? cfg_wdata : weight_q[j];
         if (eop && sel_q == IDX_WIDTH'(j))
            credit_d[j] = credit_dec;
         if (cfg_write && cfg_addr == IDX_WIDTH'(j) && credit_d[j] > cfg_wdata)
            credit_d[j] = cfg_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
         for (int j = 0; j < N_PORTS; j++) begin
            weight_q[j] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
            credit_q[j] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
         end
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         for (int j = 0; j < N_PORTS; j++) begin
            credit_q[j] <= credit_d[j];
            if (cfg_write && cfg_addr == IDX_WIDTH'(j)) weight_q[j] <= cfg_wdata;
         end
      end
   end

`ifdef PKT_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pkt_count <= '0;
      else if (eop) pkt_count <= pkt_count + PKT_COUNT_WIDTH'(1);
   end
`endif

endmodule
